// File: rtl/rom_read_ctrl_pkg.sv
// Shared types for the 128x64 ROM read front-end.
package rom_ctrl_pkg;
    localparam int ROM_AW = 7;
    localparam int ROM_DW = 64;

    typedef logic [ROM_AW-1:0] rom_adr_t;
    typedef logic [ROM_DW-1:0] rom_word_t;
endpackage

// File: rtl/rom_read_ctrl_if.sv
// Request/response bus between a requester (master) and rom_read_ctrl (slave).
interface rom_read_ctrl_if;
    import rom_ctrl_pkg::*;

    // A transfer happens on a clock edge where Valid and Ready are both high;
    // once Valid is raised the payload holds until that edge, and Ready never
    // depends combinationally on the opposite channel.
    logic      ReqValid;
    logic      ReqReady;
    rom_adr_t  ReqAdr;
    logic      RspValid;
    logic      RspReady;
    rom_word_t RspData;

    modport master (
        output ReqValid, ReqAdr, RspReady,
        input  ReqReady, RspValid, RspData
    );

    modport slave (
        input  ReqValid, ReqAdr, RspReady,
        output ReqReady, RspValid, RspData
    );
endinterface

// File: rtl/rom_read_ctrl_rsp_fifo.sv
// Circular response buffer with wrap-around pointers and a synchronous clear.
module rom_rsp_fifo
    import rom_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Clear,
    input  logic                         Push,
    input  rom_word_t                    PushData,
    input  logic                         Pop,
    output rom_word_t                    Head,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    rom_word_t      r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (Clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (Push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (Pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({Push, Pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data storage needs no reset; only entries behind a valid count are read.
    always_ff @(posedge clk) begin
        if (Push && !Clear) r_mem[r_wr_ptr] <= PushData;
    end

    assign Head  = r_mem[r_rd_ptr];
    assign Count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(Push && !Clear && (r_count == CW'(DEPTH))));
endmodule

// File: rtl/rom_read_ctrl.sv
// Valid/ready front-end for a synchronous ROM: credit cap, bypass mux, ROM drive.
module rom_read_ctrl
    import rom_ctrl_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Flush,
    rom_read_ctrl_if.slave    bus,
    output logic              RomCEB,
    output rom_adr_t          RomA,
    input  rom_word_t         RomQ
);
    localparam int CW = $clog2(DEPTH+1);

    logic           r_in_flight;
    rom_adr_t       r_last_adr;
    logic [CW-1:0]  w_count;
    logic [CW:0]    w_outstanding;
    rom_word_t      w_head;
    logic           w_accept;
    logic           w_bypass;
    logic           w_push;
    logic           w_pop;

    // Credits come from registered state only, so ReqReady never sees RspReady.
    assign w_outstanding = {1'b0, w_count} + (CW+1)'(r_in_flight);
    assign bus.ReqReady  = !reset && !Flush && (w_outstanding < (CW+1)'(DEPTH));
    assign w_accept      = bus.ReqValid && bus.ReqReady;

    assign RomCEB = !w_accept;
    assign RomA   = w_accept ? bus.ReqAdr : r_last_adr;

    assign w_bypass     = (BYPASS != 0) && (w_count == '0) && r_in_flight;
    assign bus.RspValid = !Flush && (w_bypass || (w_count != '0));
    assign bus.RspData  = w_bypass ? RomQ : w_head;

    // A stalled bypass word drops into the buffer and becomes the stable head.
    assign w_push = r_in_flight && !Flush && !(w_bypass && bus.RspReady);
    assign w_pop  = bus.RspValid && bus.RspReady && (w_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_flight <= 1'b0;
            r_last_adr  <= '0;
        end else begin
            r_in_flight <= w_accept;
            if (w_accept) r_last_adr <= bus.ReqAdr;
        end
    end

    rom_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .Clear    (Flush),
        .Push     (w_push),
        .PushData (RomQ),
        .Pop      (w_pop),
        .Head     (w_head),
        .Count    (w_count)
    );
endmodule

// File: tb/tb_rom_read_ctrl.sv
// Bench for rom_read_ctrl: three configurations share a scoreboard-based monitor.
module tb_rom_read_ctrl;
  import rom_ctrl_pkg::*;

  localparam int N = 3;  // 0: BYPASS=1 DEPTH=2, 1: BYPASS=0 DEPTH=2, 2: BYPASS=0 DEPTH=1

  logic        clk = 1'b0;
  logic        reset;
  logic        flush     [N];
  logic        req_valid [N];
  logic        req_ready [N];
  logic [6:0]  req_adr   [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [63:0] rsp_data  [N];
  logic        rom_ceb   [N];
  logic [6:0]  rom_a     [N];
  logic [63:0] rom_q     [N];

  logic [63:0] exp_q [N][$];
  int          lat_q [N][$];
  logic        chk_lat   [N];
  logic        chk_rate  [N];
  logic [6:0]  last_adr  [N];
  logic        prev_stall[N];
  logic [63:0] prev_data [N];
  int          prev_acc  [N];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    rom_read_ctrl_if ifc ();
    assign ifc.ReqValid = req_valid[g];
    assign ifc.ReqAdr   = req_adr[g];
    assign ifc.RspReady = rsp_ready[g];
    assign req_ready[g] = ifc.ReqReady;
    assign rsp_valid[g] = ifc.RspValid;
    assign rsp_data[g]  = ifc.RspData;

    rom_read_ctrl #(.DEPTH(g == 2 ? 1 : 2), .BYPASS(g == 0 ? 1 : 0)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .Flush  (flush[g]),
      .bus    (ifc),
      .RomCEB (rom_ceb[g]),
      .RomA   (rom_a[g]),
      .RomQ   (rom_q[g])
    );
  end

  function automatic logic [63:0] rom_word(input logic [6:0] a);
    return {32'hA5A5_0000 | {25'b0, a}, ~{25'b0, a}};
  endfunction

  // ROM model: registered read, output holds when not enabled
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (!rom_ceb[i]) rom_q[i] <= rom_word(rom_a[i]);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor/scoreboard, sampling on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic acc;
      acc = req_valid[i] && req_ready[i];
      if (reset) begin
        exp_q[i].delete(); lat_q[i].delete();
        last_adr[i] = '0; prev_stall[i] = 1'b0;
      end else if (flush[i]) begin
        check_eq("flush_rsp_valid", 64'(rsp_valid[i]), 64'd0);
        check_eq("flush_req_ready", 64'(req_ready[i]), 64'd0);
        exp_q[i].delete(); lat_q[i].delete();
        prev_stall[i] = 1'b0;
      end else begin
        check_eq("rom_ceb", 64'(rom_ceb[i]), 64'(!acc));
        if (acc) begin
          check_eq("rom_a_acc", 64'(rom_a[i]), 64'(req_adr[i]));
          exp_q[i].push_back(rom_word(req_adr[i]));
          lat_q[i].push_back(cyc);
          last_adr[i] = req_adr[i];
          if (i == 2) check_eq("d1_gap", 64'(cyc - prev_acc[i] >= 2), 64'd1);
          prev_acc[i] = cyc;
        end else begin
          check_eq("rom_a_hold", 64'(rom_a[i]), 64'(last_adr[i]));
        end
        if (prev_stall[i]) begin
          check_eq("stall_valid", 64'(rsp_valid[i]), 64'd1);
          check_eq("stall_data", rsp_data[i], prev_data[i]);
        end
        if (chk_rate[i]) check_eq("req_ready_hi", 64'(req_ready[i]), 64'd1);
        if (rsp_valid[i] && rsp_ready[i]) begin
          check_eq("rsp_has_exp", 64'(exp_q[i].size() != 0), 64'd1);
          if (exp_q[i].size() != 0) begin
            logic [63:0] e;
            int          t;
            e = exp_q[i].pop_front();
            t = lat_q[i].pop_front();
            check_eq("rsp_data", rsp_data[i], e);
            if (chk_lat[i]) check_eq("latency", 64'(cyc - t), (i == 0) ? 64'd1 : 64'd2);
          end
        end
        prev_stall[i] = rsp_valid[i] && !rsp_ready[i];
        prev_data[i]  = rsp_data[i];
      end
    end
    cyc++;
  end

  // Drive a request and hold it until accepted; returns at the accepting negedge
  task automatic send(input int i, input logic [6:0] adr);
    int t;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_adr[i]   = adr;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[i] && t < 100);
    check_eq("send_accept", 64'(req_ready[i]), 64'd1);
  endtask

  task automatic drain(input int i);
    int t;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    rsp_ready[i] = 1'b1;
    t = 0;
    while (exp_q[i].size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check_eq("drain_empty", 64'(exp_q[i].size()), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      flush[i] = 1'b0; req_valid[i] = 1'b0; req_adr[i] = '0; rsp_ready[i] = 1'b0;
      chk_lat[i] = 1'b0; chk_rate[i] = 1'b0; last_adr[i] = '0;
      prev_stall[i] = 1'b0; prev_data[i] = '0; prev_acc[i] = -100;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_eq("rst_rsp_valid", 64'(rsp_valid[i]), 64'd0);
      check_eq("rst_rom_ceb",   64'(rom_ceb[i]),   64'd1);
      check_eq("rst_req_ready", 64'(req_ready[i]), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Bypass streaming, full rate, address wrap back to 0
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1; chk_lat[0] = 1'b1; chk_rate[0] = 1'b1;
    for (int a = 0; a < 128; a++) send(0, 7'(a));
    send(0, 7'd0);
    chk_rate[0] = 1'b0;
    drain(0);
    chk_lat[0] = 1'b0;

    // Backpressure: two accepts then full
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0; req_valid[0] = 1'b1; req_adr[0] = 7'd0;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (req_ready[0]) n++;
      @(posedge clk); #1;
      req_adr[0] = 7'(n);
    end
    repeat (3) begin
      @(negedge clk);
      check_eq("full_req_ready", 64'(req_ready[0]), 64'd0);
      check_eq("full_rom_ceb",   64'(rom_ceb[0]),   64'd1);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (req_ready[0]) n++;
      @(posedge clk); #1;
      req_adr[0] = 7'(n);
    end
    check_eq("bp_accepts", 64'(n), 64'd5);
    drain(0);

    // Stall in the cycle the response comes straight from RomQ
    send(0, 7'h2A);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b0;
    @(negedge clk);
    check_eq("bypass_valid", 64'(rsp_valid[0]), 64'd1);
    check_eq("bypass_data",  rsp_data[0], rom_word(7'h2A));
    @(negedge clk);
    check_eq("stall_head",   rsp_data[0], rom_word(7'h2A));
    drain(0);

    // Flush with one buffered and one in flight
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    send(0, 7'd1);
    send(0, 7'd2);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    @(negedge clk);
    check_eq("post_flush_valid", 64'(rsp_valid[0]), 64'd0);
    check_eq("post_flush_ready", 64'(req_ready[0]), 64'd1);
    rsp_ready[0] = 1'b1;
    send(0, 7'd5);
    drain(0);

    // Non-bypass configurations with random addresses
    for (int i = 1; i < N; i++) begin
      @(posedge clk); #1;
      rsp_ready[i] = 1'b1; chk_lat[i] = 1'b1;
      for (int k = 0; k < 16; k++) send(i, 7'($urandom_range(0, 127)));
      drain(i);
      chk_lat[i] = 1'b0;
    end

    // Asynchronous reset in the middle of a stream
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    for (int k = 0; k < 6; k++) send(0, 7'(10 + k));
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_eq("arst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check_eq("arst_rom_ceb",   64'(rom_ceb[0]),   64'd1);
    check_eq("arst_req_ready", 64'(req_ready[0]), 64'd0);
    req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    send(0, 7'd9);
    drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
